// File: rtl/mbssoc_bus_pkg.sv
// Shared definitions for the MBSsoc cluster RAM bus: arbiter state encoding,
// index-width helper and default hold limit.
package mbssoc_bus_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StOwn  = 1'b1
  } arb_state_e;

  localparam int unsigned DefaultMaxHold = 8;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mbssoc_rr_pick.sv
// Combinational cyclic priority picker: first non-excluded requester found
// searching upward from start_i, wrapping at NumReq.
module mbssoc_rr_pick #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   start_i,
  input  logic [NumReq-1:0] excl_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  logic [NumReq-1:0] cand_req;
  logic [IdxW-1:0]   cand_idx;

  assign cand_req = req_i & ~excl_i;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand_idx = '0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      cand_idx = IdxW'((32'(start_i) + off) % NumReq);
      if (!valid_o && cand_req[cand_idx]) begin
        valid_o         = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mbssoc_ram_arbiter.sv
// Round-robin arbiter granting the shared cluster RAM port to one core at a time.
// Optional hold limit (forced release after MAX_HOLD cycles) via BUS_ARB_HOLD_LIMIT_EN.
module mbssoc_ram_arbiter
  import mbssoc_bus_pkg::*;
#(
  parameter int unsigned CORE_NUM   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_HOLD   = DefaultMaxHold
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CORE_NUM-1:0]            core_re,
  input  logic [CORE_NUM-1:0]            core_we,
  input  logic [CORE_NUM*ADDR_WIDTH-1:0] core_addr,
  output logic [CORE_NUM-1:0]            cpu_pause,
  output logic [CORE_NUM-1:0]            core_gnt,
  output logic [$clog2(CORE_NUM)-1:0]    ram_sel,
  output logic                           ram_re,
  output logic                           ram_we,
  output logic [ADDR_WIDTH-1:0]          ram_addr
);

  localparam int unsigned   IdxW    = clog2(CORE_NUM);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(CORE_NUM - 1);

  if (CORE_NUM < 2 || MAX_HOLD < 1) begin : gen_param_check
    $error("mbssoc_ram_arbiter: CORE_NUM must be >= 2 and MAX_HOLD >= 1");
  end

  arb_state_e          state_q, state_d;
  logic [CORE_NUM-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0]     sel_q, sel_d;
  logic [IdxW-1:0]     last_q, last_d;

  logic [CORE_NUM-1:0] req;
  logic [CORE_NUM-1:0] excl;
  logic [IdxW-1:0]     start;
  logic [CORE_NUM-1:0] pick_gnt;
  logic [IdxW-1:0]     pick_idx;
  logic                pick_valid;
  logic                owner_req;
  logic                force_rel;

  assign req       = core_re | core_we;
  assign owner_req = |(req & gnt_q);
  assign start     = (last_q == LastIdx) ? '0 : last_q + 1'b1;
  // Excluding the owner only matters for forced release; a dropping owner has no req anyway.
  assign excl      = (state_q == StOwn) ? gnt_q : '0;

  mbssoc_rr_pick #(
    .NumReq (CORE_NUM),
    .IdxW   (IdxW)
  ) u_pick (
    .req_i   (req),
    .start_i (start),
    .excl_i  (excl),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

`ifdef BUS_ARB_HOLD_LIMIT_EN
  localparam int unsigned HoldW = clog2(MAX_HOLD + 1);

  logic [HoldW-1:0] hold_q, hold_d;

  // Fires on the edge that ends the owner's MAX_HOLD-th cycle.
  assign force_rel = (state_q == StOwn) && ((32'(hold_q) + 32'd1) >= MAX_HOLD) && pick_valid;

  always_comb begin
    hold_d = hold_q;
    if (gnt_d != gnt_q) begin
      hold_d = '0;
    end else if (state_q == StOwn && 32'(hold_q) < MAX_HOLD) begin
      hold_d = HoldW'(32'(hold_q) + 32'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign force_rel = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StOwn;
          gnt_d   = pick_gnt;
          sel_d   = pick_idx;
          last_d  = pick_idx;
        end
      end
      StOwn: begin
        if (!owner_req || force_rel) begin
          if (pick_valid) begin
            gnt_d  = pick_gnt;
            sel_d  = pick_idx;
            last_d = pick_idx;
          end else begin
            state_d = StIdle;
            gnt_d   = '0;
            sel_d   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= LastIdx;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  // RAM mux keyed directly off the one-hot grant, so IDLE yields all zeros.
  always_comb begin
    ram_addr = '0;
    for (int i = 0; i < int'(CORE_NUM); i++) begin
      if (gnt_q[i]) ram_addr = ram_addr | core_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign ram_re    = |(core_re & gnt_q);
  assign ram_we    = |(core_we & gnt_q);
  assign ram_sel   = sel_q;
  assign core_gnt  = gnt_q;
  assign cpu_pause = req & ~gnt_q;

endmodule

// File: tb/tb_mbssoc_ram_arbiter.sv
// Scoreboard bench for mbssoc_ram_arbiter with CORE_NUM=4; honours BUS_ARB_HOLD_LIMIT_EN.
module tb_mbssoc_ram_arbiter;

`ifdef BUS_ARB_HOLD_LIMIT_EN
  localparam bit HoldEn = 1'b1;
`else
  localparam bit HoldEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   core_re, core_we, cpu_pause, core_gnt;
  logic [127:0] core_addr;
  logic [1:0]   ram_sel;
  logic         ram_re, ram_we;
  logic [31:0]  ram_addr;

  logic [31:0] addr_tab [4];

  typedef struct {
    int          cyc;
    string       nm;
    logic [3:0]  gnt;
    logic [3:0]  pause;
    logic        rre;
    logic        rwe;
    logic [31:0] raddr;
    int          sel;
  } exp_t;

  exp_t sbq [$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mbssoc_ram_arbiter #(
    .CORE_NUM   (4),
    .ADDR_WIDTH (32),
    .MAX_HOLD   (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .core_re   (core_re),
    .core_we   (core_we),
    .core_addr (core_addr),
    .cpu_pause (cpu_pause),
    .core_gnt  (core_gnt),
    .ram_sel   (ram_sel),
    .ram_re    (ram_re),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr)
  );

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h (cycle %0d)", nm, fld, act, exp, cyc);
    end
  endtask

  // Monitor: compares DUT outputs against the expectation queued for this cycle.
  exp_t m;
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      m = sbq.pop_front();
      if (m.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s.stale: got no sample expected one at cycle %0d", m.nm, m.cyc);
      end else begin
        chk(m.nm, "core_gnt", 32'(core_gnt), 32'(m.gnt));
        chk(m.nm, "cpu_pause", 32'(cpu_pause), 32'(m.pause));
        chk(m.nm, "ram_re", 32'(ram_re), 32'(m.rre));
        chk(m.nm, "ram_we", 32'(ram_we), 32'(m.rwe));
        chk(m.nm, "ram_addr", ram_addr, m.raddr);
        if (m.sel >= 0) chk(m.nm, "ram_sel", 32'(ram_sel), 32'(m.sel));
      end
    end
  end

  // Drive one cycle of requests and queue the expected outputs for that cycle.
  task automatic step_r(input logic [3:0] re, input logic [3:0] we, input logic [3:0] egnt,
                        input int esel, input string nm, input logic rst_v);
    exp_t e;
    @(posedge clk);
    #1;
    core_re = re;
    core_we = we;
    #1;
    rst_n   = rst_v;
    e.cyc   = cyc;
    e.nm    = nm;
    e.gnt   = egnt;
    e.pause = (re | we) & ~egnt;
    e.rre   = |(re & egnt);
    e.rwe   = |(we & egnt);
    e.raddr = '0;
    for (int i = 0; i < 4; i++) if (egnt[i]) e.raddr = addr_tab[i];
    e.sel   = esel;
    sbq.push_back(e);
  endtask

  task automatic step(input logic [3:0] re, input logic [3:0] we, input logic [3:0] egnt,
                      input int esel, input string nm);
    step_r(re, we, egnt, esel, nm, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    addr_tab[0] = 32'h0000_00A0;
    addr_tab[1] = 32'h0000_00B4;
    addr_tab[2] = 32'h0000_0100;
    addr_tab[3] = 32'h0000_03FC;
    rst_n   = 1'b0;
    core_re = '0;
    core_we = '0;
    for (int i = 0; i < 4; i++) core_addr[i*32 +: 32] = addr_tab[i];
    #12 rst_n = 1'b1;

    step(4'b0000, 4'b0000, 4'b0000, 0, "reset_idle");

    // Single request from core 2: one paused cycle, then granted.
    step(4'b0100, 4'b0000, 4'b0000, -1, "c2_wait");
    step(4'b0100, 4'b0000, 4'b0100, 2, "c2_grant");
    step(4'b0000, 4'b0000, 4'b0100, 2, "c2_drop");
    step(4'b0000, 4'b0000, 4'b0000, -1, "c2_idle");

    step_r(4'b0000, 4'b0000, 4'b0000, 0, "rst_a", 1'b0);
    step_r(4'b0000, 4'b0000, 4'b0000, 0, "rst_b", 1'b1);

    // All request; each drops for one cycle after its grant: 0,1,2,3,0 back to back.
    step(4'b1111, 4'b0000, 4'b0000, -1, "rr_wait");
    step(4'b1110, 4'b0000, 4'b0001, 0, "rr_g0");
    step(4'b1101, 4'b0000, 4'b0010, 1, "rr_g1");
    step(4'b1011, 4'b0000, 4'b0100, 2, "rr_g2");
    step(4'b0111, 4'b0000, 4'b1000, 3, "rr_g3");
    step(4'b1110, 4'b0000, 4'b0001, 0, "rr_g0b");
    step(4'b0000, 4'b0000, 4'b0010, 1, "rr_g1b");
    step(4'b0000, 4'b0000, 4'b0000, -1, "rr_idle");

    // Core 1 owns, core 3 waits; handoff on the edge where core 1 drops.
    step(4'b0010, 4'b0000, 4'b0000, -1, "ho_wait");
    step(4'b1010, 4'b0000, 4'b0010, 1, "ho_own1");
    step(4'b1000, 4'b0000, 4'b0010, 1, "ho_drop1");
    step(4'b1000, 4'b0000, 4'b1000, 3, "ho_own3");
    step(4'b0000, 4'b0000, 4'b1000, 3, "ho_drop3");
    step(4'b0000, 4'b0000, 4'b0000, -1, "ho_idle");

    // Core 0 holds permanently while core 1 waits.
    step(4'b0001, 4'b0000, 4'b0000, -1, "hold_wait");
    for (int k = 1; k <= 12; k++) begin
      step(4'b0011, 4'b0000, (HoldEn && k >= 9) ? 4'b0010 : 4'b0001,
           (HoldEn && k >= 9) ? 1 : 0, "hold");
    end
    step(4'b0000, 4'b0000, HoldEn ? 4'b0010 : 4'b0001, HoldEn ? 1 : 0, "hold_rel");

    // Core 2 writing; asynchronous reset mid-grant; search restarts at core 0.
    step(4'b0000, 4'b0100, 4'b0000, -1, "ar_wait");
    step(4'b0000, 4'b0100, 4'b0100, 2, "ar_own2");
    step_r(4'b0000, 4'b0100, 4'b0000, 0, "ar_async", 1'b0);
    step_r(4'b0000, 4'b0000, 4'b0000, 0, "ar_held", 1'b0);
    step_r(4'b1010, 4'b0000, 4'b0000, -1, "ar_rel", 1'b1);
    step(4'b1010, 4'b0000, 4'b0010, 1, "ar_first");
    step(4'b0000, 4'b0000, 4'b0010, 1, "ar_drop");
    step(4'b0000, 4'b0000, 4'b0000, -1, "ar_idle");

    repeat (3) @(posedge clk);
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
